// File: rtl/alu_bundle_sequencer.sv
// Two-slot VLIW bundle sequencer: issues slot 0 then slot 1 into one shared 8-bit ALU.
// Optional macro NOP_SKIP_EN: latched nop slots are not issued and their results read 0x00.
module alu_bundle_sequencer #(
    parameter int DATA_W = 8  // must match the ALU width; only 8 is supported
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bundle_valid,
    output logic              bundle_ready,
    input  logic [2:0]        op0,
    input  logic [2:0]        op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic [2:0]        alu_control,
    output logic [DATA_W-1:0] alu_src_a,
    output logic [DATA_W-1:0] alu_src_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res0,
    output logic [DATA_W-1:0] res1,
    output logic [1:0]        illegal,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE0, ISSUE1, DONE} state_t;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_ILLEGAL = 3'b100;

    state_t            state;
    logic [2:0]        op0_q, op1_q;
    logic [DATA_W-1:0] a0_q, b0_q, a1_q, b1_q;

    // NOTE: every register here is written with <= so all state updates see the
    // pre-edge values; blocking assignments would make ordering inside the block matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op0_q   <= '0;
            op1_q   <= '0;
            a0_q    <= '0;
            b0_q    <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            res0    <= '0;
            res1    <= '0;
            illegal <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bundle_valid && bundle_ready) begin
                        op0_q   <= op0;
                        op1_q   <= op1;
                        a0_q    <= a0;
                        b0_q    <= b0;
                        a1_q    <= a1;
                        b1_q    <= b1;
                        illegal <= '0;
`ifdef NOP_SKIP_EN
                        if (op0 == OP_NOP) begin
                            res0 <= '0;
                            if (op1 == OP_NOP) begin
                                res1  <= '0;
                                state <= DONE;
                            end else begin
                                state <= ISSUE1;
                            end
                        end else begin
                            state <= ISSUE0;
                        end
`else
                        state <= ISSUE0;
`endif
                    end
                end
                ISSUE0: begin
                    res0       <= alu_result;
                    illegal[0] <= (op0_q == OP_ILLEGAL);
`ifdef NOP_SKIP_EN
                    if (op1_q == OP_NOP) begin
                        res1  <= '0;
                        state <= DONE;
                    end else begin
                        state <= ISSUE1;
                    end
`else
                    state <= ISSUE1;
`endif
                end
                ISSUE1: begin
                    res1       <= alu_result;
                    illegal[1] <= (op1_q == OP_ILLEGAL);
                    state      <= DONE;
                end
                DONE: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags come from state only; rst masks them so nothing is offered during reset.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bundle_ready = 1'b0;
        res_valid    = 1'b0;
        busy         = 1'b0;
        alu_control  = OP_NOP;
        alu_src_a    = '0;
        alu_src_b    = '0;
        if (!rst) begin
            bundle_ready = (state == IDLE);
            res_valid    = (state == DONE);
            busy         = (state != IDLE);
            case (state)
                ISSUE0: begin
                    alu_control = op0_q;
                    alu_src_a   = a0_q;
                    alu_src_b   = b0_q;
                end
                ISSUE1: begin
                    alu_control = op1_q;
                    alu_src_a   = a1_q;
                    alu_src_b   = b1_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bundle_sequencer.sv
// Self-checking bench for alu_bundle_sequencer: vector table, scoreboard queue and
// hand-written sequences for stall, back-to-back and mid-operation reset.
module tb_alu_bundle_sequencer;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              bundle_valid;
    logic              bundle_ready;
    logic [2:0]        op0, op1;
    logic [DATA_W-1:0] a0, b0, a1, b1;
    logic [2:0]        alu_control;
    logic [DATA_W-1:0] alu_src_a, alu_src_b;
    logic [DATA_W-1:0] alu_result;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res0, res1;
    logic [1:0]        illegal;
    logic              busy;

    alu_bundle_sequencer #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
        .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res0(res0), .res1(res1), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b001: alu_result = alu_src_a & alu_src_b;
            3'b010: alu_result = alu_src_a | alu_src_b;
            3'b011: alu_result = alu_src_a ^ alu_src_b;
            3'b101: alu_result = alu_src_a + alu_src_b;
            3'b110: alu_result = alu_src_a - alu_src_b;
            3'b111: alu_result = alu_src_a * alu_src_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [2:0]        op0;
        logic [DATA_W-1:0] a0, b0;
        logic [2:0]        op1;
        logic [DATA_W-1:0] a1, b1;
        logic [DATA_W-1:0] r0, r1;
        logic [1:0]        ill;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] r0, r1;
        logic [1:0]        ill;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef NOP_SKIP_EN
        return 1 + int'(v.op0 != 3'b000) + int'(v.op1 != 3'b000);
`else
        return 3;
`endif
    endfunction

    task automatic drive(input vec_t v);
        op0 = v.op0; a0 = v.a0; b0 = v.b0;
        op1 = v.op1; a1 = v.a1; b1 = v.b1;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.r0 = v.r0; e.r1 = v.r1; e.ill = v.ill;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_unexpected_result"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_res0"}, res0, e.r0);
            check({tag, "_res1"}, res1, e.r1);
            check({tag, "_illegal"}, illegal, e.ill);
        end
    endtask

    // One bundle through the full handshake with res_ready held high.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit ctrl_seen;
        @(negedge clk);
        drive(v);
        bundle_valid = 1'b1;
        check({tag, "_ready"}, bundle_ready, 1'b1);
        push(v);
        @(negedge clk);
        bundle_valid = 1'b0;
        lat = 1;
        ctrl_seen = (alu_control != 3'b000);
        if (exp_lat(v) == 3 || v.op0 != 3'b000) begin
            check({tag, "_issue0_ctrl"}, alu_control, v.op0);
            check({tag, "_issue0_a"}, alu_src_a, v.a0);
            check({tag, "_issue0_b"}, alu_src_b, v.b0);
        end
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (alu_control != 3'b000) ctrl_seen = 1'b1;
        end
        check({tag, "_latency"}, lat, exp_lat(v));
        pop_compare(tag);
        if (v.op0 == 3'b000 && v.op1 == 3'b000) check({tag, "_nop_ctrl_quiet"}, ctrl_seen, 1'b0);
        @(negedge clk);
        check({tag, "_valid_drop"}, res_valid, 1'b0);
        check({tag, "_ready_back"}, bundle_ready, 1'b1);
        check({tag, "_res0_kept"}, res0, v.r0);
    endtask

    initial begin
        int acc[4];
        int bb[4];
        int idx;
        int lat;

        //           op0     a0     b0     op1     a1     b1     r0     r1     ill
        vecs[0] = '{3'b101, 8'h05, 8'h03, 3'b110, 8'h03, 8'h05, 8'h08, 8'hFE, 2'b00};
        vecs[1] = '{3'b111, 8'h10, 8'h11, 3'b001, 8'hF0, 8'h3C, 8'h10, 8'h30, 2'b00};
        vecs[2] = '{3'b100, 8'h12, 8'h34, 3'b011, 8'hAA, 8'hFF, 8'h00, 8'h55, 2'b01};
        vecs[3] = '{3'b010, 8'h0F, 8'hF0, 3'b100, 8'h77, 8'h66, 8'hFF, 8'h00, 2'b10};
        vecs[4] = '{3'b000, 8'h9A, 8'hBC, 3'b000, 8'hDE, 8'hF1, 8'h00, 8'h00, 2'b00};
        vecs[5] = '{3'b101, 8'hFF, 8'h02, 3'b110, 8'h00, 8'h01, 8'h01, 8'hFF, 2'b00};
        vecs[6] = '{3'b001, 8'hFF, 8'h81, 3'b111, 8'h0F, 8'h0F, 8'h81, 8'hE1, 2'b00};

        rst = 1'b1; bundle_valid = 1'b0; res_ready = 1'b1;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_bundle_ready", bundle_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_alu_control", alu_control, 3'b000);
        check("rst_alu_src_a", alu_src_a, 8'h00);
        check("rst_res0", res0, 8'h00);
        check("rst_res1", res1, 8'h00);
        check("rst_illegal", illegal, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bundle_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        run_vec(vecs[0], "add_sub");

        // Consumer stall in DONE: everything must hold
        @(negedge clk);
        drive(vecs[1]);
        bundle_valid = 1'b1;
        res_ready = 1'b0;
        push(vecs[1]);
        @(negedge clk);
        bundle_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall_latency", lat, exp_lat(vecs[1]));
        repeat (5) begin
            @(negedge clk);
            check("stall_res_valid", res_valid, 1'b1);
            check("stall_res0", res0, vecs[1].r0);
            check("stall_res1", res1, vecs[1].r1);
            check("stall_bundle_ready", bundle_ready, 1'b0);
            check("stall_busy", busy, 1'b1);
        end
        res_ready = 1'b1;
        pop_compare("stall");
        @(negedge clk);
        check("stall_release", res_valid, 1'b0);

        for (int i = 2; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back with bundle_valid and res_ready held high
        bb = '{0, 1, 5, 6};
        idx = 0;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && (idx < 4 || sb.size() > 0); cyc++) begin
            @(negedge clk);
            if (res_valid) pop_compare("b2b");
            if (idx < 4) begin
                drive(vecs[bb[idx]]);
                bundle_valid = 1'b1;
                if (bundle_ready) begin
                    acc[idx] = cyc;
                    push(vecs[bb[idx]]);
                    idx++;
                end
            end else begin
                bundle_valid = 1'b0;
            end
        end
        bundle_valid = 1'b0;
        check("b2b_all_accepted", idx, 4);
        check("b2b_sb_drained", sb.size(), 0);
        for (int i = 0; i < 3; i++) check($sformatf("b2b_spacing%0d", i), acc[i+1] - acc[i], 4);

        // Reset asserted while slot 1 is in the ALU
        @(negedge clk);
        drive(vecs[0]);
        bundle_valid = 1'b1;
        @(negedge clk);
        bundle_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_issue1", alu_control, vecs[0].op1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_res_valid", res_valid, 1'b0);
        check("midrst_bundle_ready", bundle_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_res0", res0, 8'h00);
        check("midrst_res1", res1, 8'h00);
        check("midrst_illegal", illegal, 2'b00);
        check("midrst_alu_control", alu_control, 3'b000);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_again", bundle_ready, 1'b1);
        check("midrst_no_valid", res_valid, 1'b0);
        run_vec(vecs[2], "after_rst");

        check("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
